// File: rtl/dist_ram_dp_param.sv
// Parametrised dual-port distributed RAM with clear sweep and optional registered reads.
// Optional parity storage/checking is enabled by defining DIST_RAM_DP_PARITY_EN.
module dist_ram_dp_param #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 7,
  parameter int                OUT_REG        = 1,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic              WCLK,
  input  logic              RSTN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic              WE,
  input  logic [ADDR_W-1:0] DPRA,
  input  logic              CLR,
  input  logic              ERR_INJ,
  output logic [DATA_W-1:0] SPO,
  output logic [DATA_W-1:0] DPO,
  output logic              BUSY,
  output logic              CLR_DONE,
  output logic              PERR_S,
  output logic              PERR_D
);
  localparam int DEPTH = 2**ADDR_W;

`ifdef DIST_RAM_DP_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [MW-1:0]     mem [DEPTH];
  logic [MW-1:0]     wword, init_word, rd_s, rd_d;
  logic              perr_s_c, perr_d_c;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy;

  assign rd_s = mem[A];
  assign rd_d = mem[DPRA];

`ifdef DIST_RAM_DP_PARITY_EN
  // Stored bit DATA_W makes the whole word even; ERR_INJ deliberately breaks that.
  assign wword     = {(^D) ^ ERR_INJ, D};
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign perr_s_c  = ^rd_s;
  assign perr_d_c  = ^rd_d;
`else
  logic unused_err_inj;
  assign unused_err_inj = ERR_INJ;
  assign wword     = D;
  assign init_word = INIT_VAL;
  assign perr_s_c  = 1'b0;
  assign perr_d_c  = 1'b0;
`endif

  always_ff @(posedge WCLK) begin
    if (!RSTN) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        IDLE: if (CLR) begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY     = busy;
  assign CLR_DONE = busy && (cnt == '1);

  // Array is never touched by reset; user writes are dropped while sweeping.
  always_ff @(posedge WCLK) begin
    if (RSTN) begin
      if (busy)    mem[cnt] <= init_word;
      else if (WE) mem[A]   <= wword;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    always_ff @(posedge WCLK) begin
      if (!RSTN) begin
        SPO    <= '0;
        DPO    <= '0;
        PERR_S <= 1'b0;
        PERR_D <= 1'b0;
      end else if (busy) begin
        SPO    <= INIT_VAL;
        DPO    <= INIT_VAL;
        PERR_S <= 1'b0;
        PERR_D <= 1'b0;
      end else begin
        SPO    <= rd_s[DATA_W-1:0];
        DPO    <= rd_d[DATA_W-1:0];
        PERR_S <= perr_s_c;
        PERR_D <= perr_d_c;
      end
    end
  end else begin : g_comb
    assign SPO    = rd_s[DATA_W-1:0];
    assign DPO    = rd_d[DATA_W-1:0];
    assign PERR_S = perr_s_c & ~busy & RSTN;
    assign PERR_D = perr_d_c & ~busy & RSTN;
  end

endmodule

// File: tb/tb_dist_ram_dp_param.sv
// Directed bench: registered-read instance plus a combinational-read twin on shared inputs.
module tb_dist_ram_dp_param;
  localparam int          DW   = 8;
  localparam int          AW   = 7;
  localparam logic [7:0]  INIT = 8'h5A;
`ifdef DIST_RAM_DP_PARITY_EN
  localparam logic        PE   = 1'b1;
`else
  localparam logic        PE   = 1'b0;
`endif

  logic          WCLK, RSTN, WE, CLR, ERR_INJ;
  logic [AW-1:0] A, DPRA;
  logic [DW-1:0] D;
  logic [DW-1:0] spo, dpo, spo0, dpo0;
  logic          busy, done, perr_s, perr_d, busy0, done0, perr_s0, perr_d0;

  int total = 0;
  int bad   = 0;
  int n, dones, done_at;

  dist_ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .INIT_VAL(INIT), .CLEAR_ON_RESET(1)) dut (
    .WCLK(WCLK), .RSTN(RSTN), .A(A), .D(D), .WE(WE), .DPRA(DPRA), .CLR(CLR), .ERR_INJ(ERR_INJ),
    .SPO(spo), .DPO(dpo), .BUSY(busy), .CLR_DONE(done), .PERR_S(perr_s), .PERR_D(perr_d));

  dist_ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .INIT_VAL(INIT), .CLEAR_ON_RESET(1)) u_comb (
    .WCLK(WCLK), .RSTN(RSTN), .A(A), .D(D), .WE(WE), .DPRA(DPRA), .CLR(CLR), .ERR_INJ(ERR_INJ),
    .SPO(spo0), .DPO(dpo0), .BUSY(busy0), .CLR_DONE(done0), .PERR_S(perr_s0), .PERR_D(perr_d0));

  initial WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  task automatic tick;
    @(posedge WCLK); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Counts BUSY cycles of one sweep; optionally pulses CLR or RSTN low on busy cycle pulse_at.
  task automatic sweep_wait(input int pulse_at, input bit is_rst,
                            output int cnt_n, output int cnt_d, output int d_at);
    cnt_n = 0; cnt_d = 0; d_at = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      cnt_n++;
      if (done) begin cnt_d++; d_at = cnt_n; end
      if (cnt_n == pulse_at) begin
        if (is_rst) RSTN = 1'b0;
        else        CLR  = 1'b1;
      end
      tick();
      RSTN = 1'b1;
      CLR  = 1'b0;
    end
  endtask

  initial begin
    RSTN = 0; WE = 0; CLR = 0; ERR_INJ = 0; A = '0; DPRA = '0; D = '0;

    // T1: reset state, then a full power-on sweep
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_spo", spo, 0);
    chk("rst_dpo", dpo, 0);
    chk("rst_done", done, 0);
    chk("rst_perr_s", perr_s, 0);
    tick();
    RSTN = 1;
    sweep_wait(-1, 0, n, dones, done_at);
    chk("t1_busy_cycles", n, 128);
    chk("t1_done_pulses", dones, 1);
    chk("t1_done_cycle", done_at, 128);
    chk("t1_idle", busy, 0);
    for (int a = 0; a < 128; a++) begin
      A = AW'(a); DPRA = AW'(127 - a);
      tick();
      chk("t1_spo_init", spo, INIT);
      chk("t1_dpo_init", dpo, INIT);
      chk("t1_spo0_init", spo0, INIT);
    end

    // T2: read-first on registered port, immediate visibility on combinational port
    A = 5; D = 8'hA5; WE = 1; DPRA = 5;
    tick();
    chk("t2_dpo_old", dpo, INIT);
    chk("t2_dpo0_new", dpo0, 8'hA5);
    WE = 0;
    tick();
    chk("t2_dpo_new", dpo, 8'hA5);
    chk("t2_spo_new", spo, 8'hA5);

    // T5 fill with address-as-data
    for (int a = 0; a < 128; a++) begin
      A = AW'(a); D = DW'(a); WE = 1;
      tick();
    end
    WE = 0; A = 77; DPRA = 3;
    tick();
    chk("t5_spo_fill", spo, 8'd77);
    chk("t5_dpo_fill", dpo, 8'd3);
    chk("t5_dpo0_fill", dpo0, 8'd3);

    // T5 + T3: CLR from IDLE, CLR again mid-sweep, writes to 127 held during sweep
    CLR = 1;
    tick();
    CLR = 0; WE = 1; A = 127; D = 8'h3C;
    chk("t5_busy_start", busy, 1);
    sweep_wait(50, 0, n, dones, done_at);
    chk("t5_busy_cycles", n, 128);
    chk("t5_done_pulses", dones, 1);
    chk("t5_done_cycle", done_at, 128);
    WE = 0; A = 127; DPRA = 77;
    tick();
    chk("t3_spo_127", spo, INIT);
    chk("t3_spo0_127", spo0, INIT);
    chk("t5_dpo_77", dpo, INIT);

    // T4: reset at sweep cycle 60 restarts the sweep
    CLR = 1;
    tick();
    CLR = 0;
    sweep_wait(60, 1, n, dones, done_at);
    chk("t4_busy_cycles", n, 188);
    chk("t4_done_pulses", dones, 1);
    chk("t4_done_cycle", done_at, 188);

    // T6: parity error injection
    A = 9; D = 8'h01; WE = 1; ERR_INJ = 1;
    tick();
    chk("t6_perr_s0_inj", perr_s0, PE);
    WE = 0; ERR_INJ = 0;
    tick();
    chk("t6_spo", spo, 8'h01);
    chk("t6_perr_s_inj", perr_s, PE);
    WE = 1;
    tick();
    WE = 0;
    tick();
    chk("t6_spo_rewr", spo, 8'h01);
    chk("t6_perr_s_ok", perr_s, 0);
    chk("t6_perr_s0_ok", perr_s0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
